// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one spi_master TX channel among N_REQ byte producers.
// Sequences the req/busy handshake for the winner and aborts grants the master never accepts.
module spi_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_REQ-1:0]                  req_i,
  input  logic [8*N_REQ-1:0]                data_i,
  output logic [N_REQ-1:0]                  ack_o,
  output logic [N_REQ-1:0]                  done_o,
  output logic                              err_o,
  output logic [$clog2(N_REQ)-1:0]          grant_id_o,
  output logic                              active_o,
  output logic                              spi_tx_req_o,
  output logic [7:0]                        spi_tx_data_o,
  input  logic                              spi_busy_i
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(BUSY_TIMEOUT);
  localparam logic [WW-1:0] WD_MAX = WW'(BUSY_TIMEOUT - 1);
  localparam logic [IW:0]   N_EXT  = (IW+1)'(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [WW-1:0] wd;
  logic          pick_found;
  logic [IW-1:0] pick_id;

  // Round-robin pick: first active request strictly after the last winner
  always_comb begin
    logic [IW:0] sum;
    pick_found = 1'b0;
    pick_id    = '0;
    sum        = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= N_EXT) begin
        sum = sum - N_EXT;
      end else begin
        sum = sum;
      end
      if (!pick_found && req_i[sum[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = sum[IW-1:0];
      end else begin
        pick_found = pick_found;
      end
    end
  end

  // Arbitration FSM with registered handshake outputs and grant watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= IW'(N_REQ - 1);
      wd            <= '0;
      ack_o         <= '0;
      done_o        <= '0;
      err_o         <= 1'b0;
      grant_id_o    <= '0;
      active_o      <= 1'b0;
      spi_tx_req_o  <= 1'b0;
      spi_tx_data_o <= 8'h00;
    end else begin
      ack_o  <= '0;
      done_o <= '0;
      err_o  <= 1'b0;
      case (state)
        IDLE: begin
          // A busy left over from some other transfer blocks new grants
          if (!spi_busy_i && pick_found) begin
            state         <= REQ;
            grant_id_o    <= pick_id;
            spi_tx_data_o <= data_i[{pick_id, 3'b000} +: 8];
            spi_tx_req_o  <= 1'b1;
            active_o      <= 1'b1;
            wd            <= '0;
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (spi_busy_i) begin
            spi_tx_req_o      <= 1'b0;
            ack_o[grant_id_o] <= 1'b1;
            state             <= BUSY;
          end else if (wd == WD_MAX) begin
            spi_tx_req_o <= 1'b0;
            active_o     <= 1'b0;
            err_o        <= 1'b1;
            ptr          <= grant_id_o;
            state        <= IDLE;
          end else begin
            wd <= wd + WW'(1);
          end
        end
        BUSY: begin
          if (!spi_busy_i) begin
            done_o[grant_id_o] <= 1'b1;
            ptr                <= grant_id_o;
            active_o           <= 1'b0;
            state              <= IDLE;
          end else begin
            state <= BUSY;
          end
        end
        default: begin
          state        <= IDLE;
          active_o     <= 1'b0;
          spi_tx_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed self-checking bench for spi_tx_arbiter (N_REQ=4, BUSY_TIMEOUT=16).
// The bench plays the spi_master side by driving spi_busy_i by hand.
module tb_spi_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  ack_o;
  logic [3:0]  done_o;
  logic        err_o;
  logic [1:0]  grant_id_o;
  logic        active_o;
  logic        spi_tx_req_o;
  logic [7:0]  spi_tx_data_o;
  logic        spi_busy_i;

  logic [7:0]  bytes [4];
  int          tests = 0;
  int          fails = 0;

  spi_tx_arbiter #(.N_REQ(4), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .data_i(data_i),
    .ack_o(ack_o), .done_o(done_o), .err_o(err_o), .grant_id_o(grant_id_o),
    .active_o(active_o), .spi_tx_req_o(spi_tx_req_o), .spi_tx_data_o(spi_tx_data_o),
    .spi_busy_i(spi_busy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_i = {bytes[3], bytes[2], bytes[1], bytes[0]};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"}, 32'(ack_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_gid"}, 32'(grant_id_o), 32'd0);
    chk({tag, "_act"}, 32'(active_o), 32'd0);
    chk({tag, "_req"}, 32'(spi_tx_req_o), 32'd0);
    chk({tag, "_data"}, 32'(spi_tx_data_o), 32'd0);
  endtask

  // One full grant/ack/done cycle; starts on the edge that must grant
  task automatic xfer(input int id);
    logic [7:0] exp_data;
    exp_data = bytes[id];
    tick();
    chk("x_req", 32'(spi_tx_req_o), 32'd1);
    chk("x_gid", 32'(grant_id_o), 32'(id));
    chk("x_data", 32'(spi_tx_data_o), 32'(exp_data));
    spi_busy_i = 1'b1;
    tick();
    chk("x_ack", 32'(ack_o), 32'(1 << id));
    chk("x_req_drop", 32'(spi_tx_req_o), 32'd0);
    spi_busy_i = 1'b0;
    tick();
    chk("x_done", 32'(done_o), 32'(1 << id));
    chk("x_act_clr", 32'(active_o), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    chk_idle_outputs("rst");
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] seen_ack_done;
    rst_n      = 1'b0;
    req_i      = 4'b0000;
    spi_busy_i = 1'b0;
    bytes[0] = 8'hA5; bytes[1] = 8'h11; bytes[2] = 8'h22; bytes[3] = 8'h33;
    do_reset();
    tick();
    chk_idle_outputs("post_rst");

    // Single transfer from requester 0; data0 changes after the grant
    req_i = 4'b0001;
    tick();
    chk("t1_req", 32'(spi_tx_req_o), 32'd1);
    chk("t1_data", 32'(spi_tx_data_o), 32'hA5);
    chk("t1_act", 32'(active_o), 32'd1);
    bytes[0] = 8'h3C;
    tick();
    chk("t1_req_hold", 32'(spi_tx_req_o), 32'd1);
    spi_busy_i = 1'b1;
    tick();
    chk("t1_ack", 32'(ack_o), 32'b0001);
    chk("t1_req_drop", 32'(spi_tx_req_o), 32'd0);
    req_i = 4'b0000;
    tick();
    chk("t1_ack_single", 32'(ack_o), 32'd0);
    chk("t1_no_done_yet", 32'(done_o), 32'd0);
    spi_busy_i = 1'b0;
    tick();
    chk("t1_done", 32'(done_o), 32'b0001);
    chk("t1_data_held", 32'(spi_tx_data_o), 32'hA5);
    tick();
    chk("t1_done_single", 32'(done_o), 32'd0);
    chk("t6_data_held_idle", 32'(spi_tx_data_o), 32'hA5);

    // Reset in BUSY abandons the transfer; requester 0 wins first afterwards
    req_i = 4'b0100;
    xfer_to_busy: begin
      tick();
      chk("t5_gid", 32'(grant_id_o), 32'd2);
      spi_busy_i = 1'b1;
      tick();
      chk("t5_ack", 32'(ack_o), 32'b0100);
    end
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("t5_async");
    spi_busy_i = 1'b0;
    req_i      = 4'b1001;
    #1;
    rst_n = 1'b1;
    xfer(0);
    chk("t6_new_data", 32'(spi_tx_data_o), 32'h3C);
    xfer(3);
    req_i = 4'b0000;

    // Fresh reset, all four requesting: strict rotation 0..3 twice
    do_reset();
    req_i = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      xfer(k % 4);
    end

    // Last winner 1, then 1 and 3 request: 3 goes first
    req_i = 4'b0010;
    xfer(1);
    req_i = 4'b1010;
    xfer(3);
    xfer(1);
    req_i = 4'b0000;

    // Master never answers: watchdog aborts, pending requester 2 goes next
    tick();
    req_i = 4'b0001;
    tick();
    chk("t4_gid", 32'(grant_id_o), 32'd0);
    chk("t4_req", 32'(spi_tx_req_o), 32'd1);
    req_i = 4'b0101;
    seen_ack_done = 4'b0000;
    for (int k = 0; k < 15; k++) begin
      tick();
      seen_ack_done = seen_ack_done | ack_o | done_o | {3'b000, err_o};
    end
    chk("t4_no_early", 32'(seen_ack_done), 32'd0);
    chk("t4_req_held", 32'(spi_tx_req_o), 32'd1);
    tick();
    chk("t4_err", 32'(err_o), 32'd1);
    chk("t4_req_drop", 32'(spi_tx_req_o), 32'd0);
    chk("t4_act_drop", 32'(active_o), 32'd0);
    chk("t4_no_ack", 32'(ack_o | done_o), 32'd0);
    tick();
    chk("t4_err_single", 32'(err_o), 32'd0);
    chk("t4_next_gid", 32'(grant_id_o), 32'd2);
    chk("t4_next_req", 32'(spi_tx_req_o), 32'd1);
    spi_busy_i = 1'b1;
    tick();
    chk("t4_next_ack", 32'(ack_o), 32'b0100);
    req_i = 4'b0000;
    spi_busy_i = 1'b0;
    tick();
    chk("t4_next_done", 32'(done_o), 32'b0100);

    // Stale busy in IDLE holds off any grant
    req_i      = 4'b0001;
    spi_busy_i = 1'b1;
    tick();
    tick();
    chk("stale_act", 32'(active_o), 32'd0);
    chk("stale_req", 32'(spi_tx_req_o), 32'd0);
    spi_busy_i = 1'b0;
    tick();
    chk("stale_grant", 32'(spi_tx_req_o), 32'd1);
    chk("stale_gid", 32'(grant_id_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
